// File: rtl/boot_load_sequencer_if.sv
// Avalon-MM bus between the boot load sequencer (master) and the
// interconnect carrying the SD driver and PIO slaves.
interface boot_load_sequencer_if;
  logic [27:0] address;
  logic [3:0]  byteenable;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, byteenable, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, byteenable, write, writedata, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/boot_load_sequencer.sv
// Holds ao486 in reset, loads BIOS and VBIOS through the SD driver with status
// polling, then releases reset. Optional poll timeout: BOOT_LOAD_TIMEOUT_EN.
module boot_load_sequencer #(
  parameter logic [31:0] PIO_OUTPUT_ADDR = 32'h0000_8860,
  parameter logic [31:0] DRIVER_SD_ADDR  = 32'h0000_0000,
  parameter logic [31:0] POWERUP_DELAY   = 32'd20_000_000,
  parameter logic [31:0] POLL_GAP        = 32'd1000,
`ifdef BOOT_LOAD_TIMEOUT_EN
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd50_000_000,
`endif
  parameter logic [31:0] BIOS_SECTOR     = 32'd72,
  parameter logic [31:0] BIOS_SIZE       = 32'd65536,
  parameter logic [31:0] BIOS_ADDR       = 32'h080F_0000,
  parameter logic [31:0] VBIOS_SECTOR    = 32'd8,
  parameter logic [31:0] VBIOS_SIZE      = 32'd32768,
  parameter logic [31:0] VBIOS_ADDR      = 32'h080C_0000,
  parameter logic [31:0] CTRL_READ       = 32'd2,
  parameter logic [2:0]  STATUS_IDLE     = 3'd2,
  parameter logic [2:0]  STATUS_ERROR    = 3'd5
) (
  input  logic                          clk,
  input  logic                          rst,
  boot_load_sequencer_if.master         bus,
  output logic                          done,
  output logic                          error,
  output logic                          job
);

  typedef enum logic [3:0] {
    INIT_WAIT, HOLD, POLL_PRE, WR_ADDR, WR_SECTOR, WR_COUNT, WR_CTRL,
    POLL, RELEASE, DONE, FAIL
  } state_t;

  localparam logic [31:0] DELAY_LAST  = (POWERUP_DELAY != 0) ? POWERUP_DELAY - 1 : '0;
  localparam logic [31:0] GAP_LAST    = (POLL_GAP != 0) ? POLL_GAP - 1 : '0;
  localparam logic [31:0] BIOS_COUNT  = BIOS_SIZE >> 9;
  localparam logic [31:0] VBIOS_COUNT = VBIOS_SIZE >> 9;
  localparam logic [27:0] PIO_REG     = PIO_OUTPUT_ADDR[27:0];
  localparam logic [27:0] DRV_BASE    = DRIVER_SD_ADDR[27:0];

  state_t      state;
  logic [31:0] cnt;
  logic [27:0] wr_addr;
  logic [31:0] wr_data;
  state_t      wr_next;
  logic [2:0]  status;
  logic        timed_out;
  logic        unused_readdata;

  assign status          = bus.readdata[2:0];
  assign unused_readdata = ^bus.readdata[31:3];

`ifdef BOOT_LOAD_TIMEOUT_EN
  // Cycles spent in the current polling state; zero in every other state so
  // each entry into POLL_PRE/POLL starts a fresh window.
  logic [31:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || (state != POLL_PRE && state != POLL)) wait_cnt <= '0;
    else if (wait_cnt < TIMEOUT_CYCLES)                wait_cnt <= wait_cnt + 32'd1;
  end

  assign timed_out = (wait_cnt >= TIMEOUT_CYCLES);
`else
  assign timed_out = 1'b0;
`endif

  // Target, payload and successor of whichever write the current state issues.
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    wr_addr = DRV_BASE;
    wr_data = '0;
    wr_next = state;
    case (state)
      HOLD:      begin wr_addr = PIO_REG; wr_data = 32'd1; wr_next = POLL_PRE; end
      WR_ADDR:   begin wr_data = job ? VBIOS_ADDR : BIOS_ADDR; wr_next = WR_SECTOR; end
      WR_SECTOR: begin
        wr_addr = DRV_BASE + 28'd4;
        wr_data = job ? VBIOS_SECTOR : BIOS_SECTOR;
        wr_next = WR_COUNT;
      end
      WR_COUNT:  begin
        wr_addr = DRV_BASE + 28'd8;
        wr_data = job ? VBIOS_COUNT : BIOS_COUNT;
        wr_next = WR_CTRL;
      end
      WR_CTRL:   begin wr_addr = DRV_BASE + 28'd12; wr_data = CTRL_READ; wr_next = POLL; end
      RELEASE:   begin wr_addr = PIO_REG; wr_data = 32'd0; wr_next = DONE; end
      default:   ;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= INIT_WAIT;
      cnt            <= '0;
      bus.address    <= '0;
      bus.byteenable <= '0;
      bus.write      <= 1'b0;
      bus.writedata  <= '0;
      bus.read       <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      job            <= 1'b0;
    end else begin
      case (state)
        INIT_WAIT: begin
          if (cnt >= DELAY_LAST) begin
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        HOLD, WR_ADDR, WR_SECTOR, WR_COUNT, WR_CTRL, RELEASE: begin
          if (!bus.write) begin
            bus.write      <= 1'b1;
            bus.byteenable <= 4'b1111;
            bus.address    <= wr_addr;
            bus.writedata  <= wr_data;
          end else if (!bus.waitrequest) begin
            bus.write      <= 1'b0;
            bus.byteenable <= '0;
            bus.address    <= '0;
            bus.writedata  <= '0;
            state          <= wr_next;
            if (state == RELEASE) done <= 1'b1;
          end
        end

        POLL_PRE, POLL: begin
          if (bus.read) begin
            if (!bus.waitrequest) begin
              bus.read       <= 1'b0;
              bus.byteenable <= '0;
              bus.address    <= '0;
              if (status == STATUS_IDLE) begin
                if (state == POLL_PRE) begin
                  state <= WR_ADDR;
                end else if (!job) begin
                  job   <= 1'b1;
                  state <= WR_ADDR;
                end else begin
                  state <= RELEASE;
                end
              end else if (status == STATUS_ERROR || timed_out) begin
                error <= 1'b1;
                state <= FAIL;
              end
            end
          end else if (timed_out) begin
            error <= 1'b1;
            state <= FAIL;
          end else if (cnt >= GAP_LAST) begin
            cnt            <= '0;
            bus.read       <= 1'b1;
            bus.byteenable <= 4'b1111;
            bus.address    <= DRV_BASE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: ;  // DONE and FAIL keep the bus idle until reset
      endcase
    end
  end

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Directed bench for boot_load_sequencer: bus slave model, expected write
// table and a per-cycle compare process.
module tb_boot_load_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done, error, job;

  boot_load_sequencer_if bus();

  boot_load_sequencer #(
    .POWERUP_DELAY (32'd16),
`ifdef BOOT_LOAD_TIMEOUT_EN
    .TIMEOUT_CYCLES(32'd200),
`endif
    .POLL_GAP      (32'd4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .done (done),
    .error(error),
    .job  (job)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected accepted writes, straight from the boot recipe.
  logic [27:0] exp_addr [10] = '{28'h0008860, 28'h0, 28'h4, 28'h8, 28'hC,
                                 28'h0,       28'h4, 28'h8, 28'hC, 28'h0008860};
  logic [31:0] exp_data [10] = '{32'd1, 32'h080F0000, 32'd72, 32'd128, 32'd2,
                                 32'h080C0000, 32'd8, 32'd64, 32'd2, 32'd0};

  // Stimulus modes
  logic rand_wait = 0, err_mode = 0, stuck_mode = 0, hold_sector = 0, to_mode = 0;

  // ---------------- slave model ----------------
  int  busy = 0, ctrl_cnt = 0, wait_left = 0;
  bit  in_req = 0, gave_ok = 0, last_ctrl = 0;

  function automatic logic [2:0] slave_status();
    if (err_mode && ctrl_cnt >= 1)   return 3'd5;
    if (stuck_mode && ctrl_cnt >= 1) return 3'd1;
    if (busy > 0)                    return 3'd1;
    return 3'd2;
  endfunction

  initial begin
    bus.waitrequest = 1'b0;
    bus.readdata    = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        in_req = 0; gave_ok = 0; busy = 0; ctrl_cnt = 0;
        bus.waitrequest = 1'b0; bus.readdata = '0;
      end else begin
        if (busy > 0) busy--;
        if (gave_ok) begin
          if (last_ctrl) begin busy = 50; ctrl_cnt++; end
          in_req = 0; gave_ok = 0;
        end
        bus.waitrequest = 1'b0;
        bus.readdata    = '0;
        if (bus.read || bus.write) begin
          if (!in_req) begin
            in_req = 1;
            wait_left = rand_wait ? int'($urandom_range(7, 0)) : 0;
            if (hold_sector && bus.write && bus.address == 28'h4) wait_left = 1000000;
          end
          if (wait_left > 0) begin
            bus.waitrequest = 1'b1;
            wait_left--;
          end else begin
            gave_ok   = 1;
            last_ctrl = bus.write && bus.address == 28'hC;
            if (bus.read) bus.readdata = {$urandom_range(32'hFFFF, 0), 13'h0, slave_status()};
          end
        end
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  int  wr_idx = 0, reads_acc = 0;
  bit  done_exp = 0, error_exp = 0, job_exp = 0;
  bit  prev_rst = 1, hold_prev = 0, prev_rd = 0, prev_wr = 0;
  logic [27:0] prev_addr;
  logic [31:0] prev_wdata;

  initial forever begin
    @(negedge clk);
    if (prev_rst) begin
      check("rst_write", bus.write, 0);
      check("rst_read",  bus.read, 0);
      check("rst_be",    bus.byteenable, 0);
      check("rst_done",  done, 0);
      check("rst_error", error, 0);
      check("rst_job",   job, 0);
      wr_idx = 0; done_exp = 0; error_exp = 0; job_exp = 0; hold_prev = 0;
    end else begin
      check("be_rule", bus.byteenable, (bus.read || bus.write) ? 4'hF : 4'h0);
      check("rd_wr_excl", bus.read && bus.write, 0);
      check("done", done, done_exp);
      if (!to_mode) check("error", error, error_exp);
      check("job", job, job_exp);
      if (done_exp || error_exp) check("idle_after_end", bus.read || bus.write, 0);
      if (hold_prev) begin
        check("hold_rd",   bus.read, prev_rd);
        check("hold_wr",   bus.write, prev_wr);
        check("hold_addr", bus.address, prev_addr);
        if (prev_wr) check("hold_wdata", bus.writedata, prev_wdata);
      end
      if (bus.read) check("read_addr", bus.address, 28'h0);
      if ((bus.read || bus.write) && !bus.waitrequest && !rst) begin
        if (bus.write) begin
          if (wr_idx < 10) begin
            check($sformatf("wr%0d_addr", wr_idx), bus.address, exp_addr[wr_idx]);
            check($sformatf("wr%0d_data", wr_idx), bus.writedata, exp_data[wr_idx]);
          end else begin
            check("extra_write", wr_idx, 10);
          end
          if (wr_idx == 9) done_exp = 1;
          wr_idx++;
        end else begin
          reads_acc++;
          if (bus.readdata[2:0] == 3'd5) error_exp = 1;
          else if (bus.readdata[2:0] == 3'd2 && wr_idx == 5) job_exp = 1;
        end
      end
    end
    hold_prev  = (bus.read || bus.write) && bus.waitrequest && !rst;
    prev_rd    = bus.read;
    prev_wr    = bus.write;
    prev_addr  = bus.address;
    prev_wdata = bus.writedata;
    prev_rst   = rst;
  end

  // ---------------- directed sequence ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic restart_and_measure(input string tag);
    int edges = 0;
    rst = 1'b0;
    while (!bus.write && edges < 100) begin step(1); edges++; end
    check({tag, "_powerup_window"}, (edges >= 16 && edges <= 18), 1);
    check({tag, "_first_addr"}, bus.address, 28'h0008860);
    check({tag, "_first_data"}, bus.writedata, 32'd1);
  endtask

  task automatic wait_end(input string tag, input int budget);
    int c = 0;
    while (!(done || error) && c < budget) begin step(1); c++; end
    check({tag, "_finished_in_budget"}, (done || error), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
  endtask

  initial begin
    int t0, r0;
    step(3);
    check("reset_address", bus.address, 28'h0);
    check("reset_done", done, 0);

    // Normal boot, no stalls
    restart_and_measure("a");
    wait_end("a", 5000);
    check("a_done", done, 1);
    check("a_error", error, 0);
    check("a_writes", wr_idx, 10);
    check("a_job", job, 1);

    // Random stalls on every access
    rand_wait = 1;
    do_reset();
    restart_and_measure("b");
    wait_end("b", 8000);
    check("b_done", done, 1);
    check("b_error", error, 0);
    check("b_writes", wr_idx, 10);
    rand_wait = 0;

    // Driver error during the BIOS poll
    err_mode = 1;
    do_reset();
    restart_and_measure("c");
    wait_end("c", 5000);
    step(300);
    check("c_error", error, 1);
    check("c_done", done, 0);
    check("c_writes", wr_idx, 5);
    check("c_job", job, 0);
    err_mode = 0;

    // Status stuck busy
    stuck_mode = 1;
    do_reset();
    restart_and_measure("d");
    t0 = 0;
    while (ctrl_cnt < 1 && t0 < 2000) begin step(1); t0++; end
    check("d_ctrl_seen", ctrl_cnt, 1);
`ifdef BOOT_LOAD_TIMEOUT_EN
    to_mode = 1;
    t0 = 1;
    while (!error && t0 < 400) begin step(1); t0++; end
    check("d_timeout_error", error, 1);
    check("d_timeout_window", (t0 >= 190 && t0 <= 215), 1);
    error_exp = 1;
    step(50);
    check("d_no_release", wr_idx, 5);
    check("d_done", done, 0);
`else
    r0 = reads_acc;
    step(10000);
    check("d_no_error", error, 0);
    check("d_no_done", done, 0);
    check("d_still_polling", (reads_acc - r0) > 100, 1);
`endif
    stuck_mode = 0;

    // Reset while a WR_SECTOR write is stalled
    rst = 1'b1; to_mode = 0;
    step(2);
    hold_sector = 1;
    rst = 1'b0;
    t0 = 0;
    while (!(bus.write && bus.address == 28'h4) && t0 < 500) begin step(1); t0++; end
    check("e_sector_reached", bus.write && bus.address == 28'h4, 1);
    step(2);
    check("e_still_stalled", bus.write, 1);
    rst = 1'b1; hold_sector = 0;
    step(1);
    check("e_write_dropped", bus.write, 0);
    check("e_addr_cleared", bus.address, 28'h0);
    check("e_done", done, 0);
    check("e_job", job, 0);
    restart_and_measure("e");
    wait_end("e", 5000);
    check("e_done_after", done, 1);
    check("e_writes", wr_idx, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/boot_load_sequencer.md
Name: boot_load_sequencer

Overview:
Avalon-MM master that replaces fixed-delay boot loading with a status-polled sequence. Holds ao486 in reset via the PIO, then programs the SD driver to copy the BIOS and VBIOS into SDRAM, polling the driver status register between jobs. Releases ao486 reset only after both loads complete. Sits on the system interconnect alongside the SD driver slave and PIO slave.

Parameters:
PIO_OUTPUT_ADDR, 32'h00008860, PIO register address; bit0=1 holds ao486 in reset.
DRIVER_SD_ADDR, 32'h00000000, SD driver base: +0 dest addr (write) / status (read), +4 sector, +8 count, +12 control.
POWERUP_DELAY, 20000000, cycles waited after reset before the first bus access.
POLL_GAP, 1000, idle cycles between status reads.
TIMEOUT_CYCLES, 50000000, per-wait poll limit (only with the optional feature).
BIOS_SECTOR, 72, BIOS start sector.  BIOS_SIZE, 65536, BIOS bytes.  BIOS_ADDR, 32'h080F0000, BIOS destination.
VBIOS_SECTOR, 8, VBIOS start sector.  VBIOS_SIZE, 32768, VBIOS bytes.  VBIOS_ADDR, 32'h080C0000, VBIOS destination.
CTRL_READ, 2, control value that starts a read.  STATUS_IDLE, 2, status[2:0] idle code.  STATUS_ERROR, 5, status[2:0] error code.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
address  out  28  Avalon byte address
byteenable  out  4  always 4'b1111 during a transfer, else 0
write  out  1  Avalon write request
writedata  out  32  write data
read  out  1  Avalon read request
readdata  in  32  read data, valid in the cycle read=1 and waitrequest=0
waitrequest  in  1  slave stall
done  out  1  sticky; both images loaded and ao486 reset released
error  out  1  sticky; driver error or timeout; ao486 stays in reset
job  out  1  current image: 0=BIOS, 1=VBIOS

Behaviour:
- Reset: all outputs 0; state INIT_WAIT; counters cleared. Reset at any point aborts the in-flight transfer (read/write drop next cycle) and restarts from INIT_WAIT.
- Bus rule: a request holds address/writedata/byteenable stable while waitrequest=1; completes in the first cycle with waitrequest=0; read/write deassert the following cycle. At most one request outstanding; never read and write together.
- States:
  INIT_WAIT: count POWERUP_DELAY cycles -> HOLD.
  HOLD: write 1 to PIO_OUTPUT_ADDR -> POLL_PRE.
  POLL_PRE: wait POLL_GAP, read DRIVER_SD_ADDR+0; status IDLE -> WR_ADDR; ERROR -> FAIL; else repeat.
  WR_ADDR/WR_SECTOR/WR_COUNT/WR_CTRL: four writes to +0/+4/+8/+12 with the job's addr, sector, size/512, CTRL_READ; each state advances on completion.
  POLL: wait POLL_GAP cycles, then read status; IDLE -> next job (job 0 -> job=1, WR_ADDR) or, after job 1, RELEASE; ERROR -> FAIL; other -> repeat. The driver leaves IDLE within one cycle of the control write, so the first POLL_GAP is sufficient.
  RELEASE: write 0 to PIO_OUTPUT_ADDR -> DONE.
  DONE: done=1, bus idle forever. FAIL: error=1, bus idle forever; no PIO release.
- Sector count = SIZE>>9 computed at elaboration; SIZE must be a multiple of 512 (non-multiples are truncated).
- Status codes other than IDLE/ERROR are treated as busy. readdata[31:3] ignored.
- done and error mutually exclusive; both clear only on rst.
- job changes only on the POLL->WR_ADDR transition.

Optional Feature:
BOOT_LOAD_TIMEOUT_EN: defined -> a counter, cleared on entry to POLL_PRE/POLL, counts cycles in that state; reaching TIMEOUT_CYCLES before an IDLE status -> FAIL (error=1), ending any outstanding read normally first. Undefined -> counter absent; polling continues indefinitely.

Test Plan:
POWERUP_DELAY=16, POLL_GAP=4, slave returns IDLE except 50 busy cycles after each control write -> writes in order: PIO<=1; +0<=080F0000, +4<=72, +8<=128, +12<=2; +0<=080C0000, +4<=8, +8<=64, +12<=2; PIO<=0; done=1, error=0.
Random waitrequest 0-7 cycles on every access -> identical write sequence, each request's address/writedata stable until accept, no dropped or duplicated transfers.
Status returns 5 during BIOS poll -> error=1 within one cycle of the read accept, no VBIOS writes, no PIO<=0, done=0.
BOOT_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=200, status stuck at 1 -> error=1 ~200 cycles after POLL entry, bus idle afterwards; without the macro, still polling after 10000 cycles.
rst pulsed during WR_SECTOR with waitrequest=1 -> write=0 next cycle, all outputs 0, sequence restarts with 16-cycle delay then PIO<=1.
job observed 0 through the BIOS poll and 1 from the VBIOS WR_ADDR onward.
